t05_header_serializer: RTL and testbench

Parametrised successor to the Huffman header writer. It turns a stream of tree-walk commands into the serial header bitstream:
- the first leaf's path bits,
- then a `1` marker and the character code for each leaf,
- a `0` for each backtrack,
- zero padding to an alignment boundary on END.

It sits between the codebook/tree-walk FSM and the SPI/flash bit writer. Unlike the previous block it uses valid/ready handshakes in both directions, a variable-length path, and a running bit count.

---
 rtl/t05_header_serializer_pkg.sv | 25 ++
 rtl/t05_header_serializer_if.sv | 32 +++
 rtl/t05_header_serializer_hdr_shift.sv | 47 ++++
 rtl/t05_header_serializer.sv | 176 +++++++++++++++++
 tb/tb_t05_header_serializer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/t05_header_serializer_pkg.sv
// Shared command/state types and the alignment helper for the header serializer.
package t05_pkg;

    typedef enum logic [1:0] {
        CMD_LEAF = 2'd0,
        CMD_BACK = 2'd1,
        CMD_END  = 2'd2
    } hdr_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PATH = 3'd1,
        ST_MARK = 3'd2,
        ST_CHAR = 3'd3,
        ST_ZERO = 3'd4,
        ST_PAD  = 3'd5,
        ST_DONE = 3'd6
    } hdr_state_t;

    // align is a power of two, so a mask test replaces the modulo.
    function automatic logic is_aligned(input logic [31:0] cnt, input int align);
        return (cnt & 32'(align - 1)) == 32'd0;
    endfunction

endpackage

// File: rtl/t05_header_serializer_if.sv
// Command and bit-stream handshake bundle between tree-walk FSM, serializer and bit writer.
interface t05_hdr_if
    import t05_pkg::*;
#(
    parameter int CHAR_W = 8,
    parameter int PATH_W = 128,
    parameter int CNT_W  = 16
) ();
    localparam int LEN_W = $clog2(PATH_W + 1);

    logic              cmd_valid;
    logic              cmd_ready;
    hdr_cmd_t          cmd_type;
    logic [CHAR_W-1:0] cmd_char;
    logic [PATH_W-1:0] cmd_path;
    logic [LEN_W-1:0]  cmd_path_len;
    logic              bit_valid;
    logic              bit_ready;
    logic              bit_out;
    logic [CNT_W-1:0]  hdr_bits;
    logic              done;

    modport master (
        output cmd_valid, cmd_type, cmd_char, cmd_path, cmd_path_len, bit_ready,
        input  cmd_ready, bit_valid, bit_out, hdr_bits, done
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_char, cmd_path, cmd_path_len, bit_ready,
        output cmd_ready, bit_valid, bit_out, hdr_bits, done
    );
endinterface

// File: rtl/t05_header_serializer_hdr_shift.sv
// Loadable MSB-first bit source with its own index; nxt_o is the bit that is current after this edge.
module t05_hdr_shift #(
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic                   shift_i,
    input  logic [W-1:0]           data_i,
    input  logic [$clog2(W+1)-1:0] len_i,
    output logic                   nxt_o,
    output logic                   last_o
);
    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]     data_q, data_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] load_idx;

    assign load_idx = IDX_W'(len_i - 1'b1);

    always_comb begin
        data_d = data_q;
        idx_d  = idx_q;
        if (load_i) begin
            data_d = data_i;
            idx_d  = load_idx;
        end else if (shift_i) begin
            idx_d = idx_q - 1'b1;
        end
    end

    // Lookahead lets the parent register bit_out in the same cycle the index moves.
    assign nxt_o  = data_d[idx_d];
    assign last_o = (idx_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            idx_q  <= '0;
        end else begin
            data_q <= data_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/t05_header_serializer.sv
// Header serializer: tree-walk commands in, registered header bitstream out.
// state | meaning: IDLE wait cmd | PATH first-leaf path | MARK leaf '1' | CHAR code | ZERO backtrack | PAD align | DONE end pulse
module t05_header_serializer
    import t05_pkg::*;
#(
    parameter int CHAR_W = 8,
    parameter int PATH_W = 128,
    parameter int ALIGN  = 8,
    parameter int CNT_W  = 16
) (
    input  logic     clk,
    input  logic     rst,
    t05_hdr_if.slave bus
);
    localparam int PLEN_W = $clog2(PATH_W + 1);
    localparam int CLEN_W = $clog2(CHAR_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    hdr_state_t       state_q;
    logic             bit_valid_q;
    logic             bit_out_q;
    logic             done_q;
    logic             first_q;
    logic [CNT_W-1:0] hdr_bits_q;

    logic              accept;
    logic              xfer;
    logic              leaf_load;
    logic              path_shift;
    logic              char_shift;
    logic              path_nxt;
    logic              path_last;
    logic              char_nxt;
    logic              char_last;
    logic [PLEN_W-1:0] path_len_c;
    logic [CNT_W-1:0]  hdr_inc;

    assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;
    assign bus.bit_valid = bit_valid_q;
    assign bus.bit_out   = bit_out_q;
    assign bus.hdr_bits  = hdr_bits_q;
    assign bus.done      = done_q;

    assign accept     = bus.cmd_valid && bus.cmd_ready;
    assign xfer       = bit_valid_q && bus.bit_ready;
    assign leaf_load  = accept && (bus.cmd_type == CMD_LEAF);
    assign path_shift = xfer && (state_q == ST_PATH);
    assign char_shift = xfer && (state_q == ST_CHAR);
    assign path_len_c = (bus.cmd_path_len > PLEN_W'(PATH_W)) ? PLEN_W'(PATH_W) : bus.cmd_path_len;
    assign hdr_inc    = (hdr_bits_q == CNT_MAX) ? hdr_bits_q : hdr_bits_q + 1'b1;

    t05_hdr_shift #(.W(PATH_W)) u_path (
        .clk     (clk),
        .rst     (rst),
        .load_i  (leaf_load),
        .shift_i (path_shift),
        .data_i  (bus.cmd_path),
        .len_i   (path_len_c),
        .nxt_o   (path_nxt),
        .last_o  (path_last)
    );

    t05_hdr_shift #(.W(CHAR_W)) u_char (
        .clk     (clk),
        .rst     (rst),
        .load_i  (leaf_load),
        .shift_i (char_shift),
        .data_i  (bus.cmd_char),
        .len_i   (CLEN_W'(CHAR_W)),
        .nxt_o   (char_nxt),
        .last_o  (char_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_valid_q <= 1'b0;
            bit_out_q   <= 1'b0;
            done_q      <= 1'b0;
            first_q     <= 1'b1;
            hdr_bits_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (xfer) begin
                hdr_bits_q <= hdr_inc;
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (bus.cmd_type)
                            CMD_LEAF: begin
                                first_q     <= 1'b0;
                                bit_valid_q <= 1'b1;
                                if (first_q && (path_len_c != '0)) begin
                                    state_q   <= ST_PATH;
                                    bit_out_q <= path_nxt;
                                end else begin
                                    state_q   <= ST_MARK;
                                    bit_out_q <= 1'b1;
                                end
                            end
                            CMD_BACK: begin
                                state_q     <= ST_ZERO;
                                bit_valid_q <= 1'b1;
                                bit_out_q   <= 1'b0;
                            end
                            CMD_END: begin
                                if (is_aligned(32'(hdr_bits_q), ALIGN)) begin
                                    state_q <= ST_DONE;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q     <= ST_PAD;
                                    bit_valid_q <= 1'b1;
                                    bit_out_q   <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_PATH: begin
                    if (xfer) begin
                        if (path_last) begin
                            state_q   <= ST_MARK;
                            bit_out_q <= 1'b1;
                        end else begin
                            bit_out_q <= path_nxt;
                        end
                    end
                end
                ST_MARK: begin
                    if (xfer) begin
                        state_q   <= ST_CHAR;
                        bit_out_q <= char_nxt;
                    end
                end
                ST_CHAR: begin
                    if (xfer) begin
                        if (char_last) begin
                            state_q     <= ST_IDLE;
                            bit_valid_q <= 1'b0;
                            bit_out_q   <= 1'b0;
                        end else begin
                            bit_out_q <= char_nxt;
                        end
                    end
                end
                ST_ZERO: begin
                    if (xfer) begin
                        state_q     <= ST_IDLE;
                        bit_valid_q <= 1'b0;
                    end
                end
                ST_PAD: begin
                    // A saturated count is used as-is for the alignment test.
                    if (xfer && is_aligned(32'(hdr_inc), ALIGN)) begin
                        state_q     <= ST_DONE;
                        bit_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q    <= ST_IDLE;
                    hdr_bits_q <= '0;
                    first_q    <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    bit_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t05_header_serializer.sv
// Bench for the header serializer: directed test-plan cases plus randomized commands against a bit-queue model.
module tb_t05_header_serializer;
    import t05_pkg::*;

    localparam int CHAR_W = 8;
    localparam int PATH_W = 128;
    localparam int ALIGN  = 8;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: first-leaf flag and bits emitted since reset/END.
    bit m_first = 1'b1;
    int m_cnt   = 0;

    t05_hdr_if #(.CHAR_W(CHAR_W), .PATH_W(PATH_W), .CNT_W(CNT_W)) bus ();

    t05_header_serializer #(
        .CHAR_W (CHAR_W),
        .PATH_W (PATH_W),
        .ALIGN  (ALIGN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void model_cmd(input hdr_cmd_t t, input logic [7:0] ch, input logic [127:0] p,
                                      input int len, output bit e[$], output int e_done);
        int l;
        e      = {};
        e_done = 0;
        if (t == CMD_LEAF) begin
            l = (len > PATH_W) ? PATH_W : len;
            if (m_first) begin
                for (int i = l - 1; i >= 0; i--) e.push_back(p[i]);
            end
            e.push_back(1'b1);
            for (int i = CHAR_W - 1; i >= 0; i--) e.push_back(ch[i]);
            m_first = 1'b0;
        end else if (t == CMD_BACK) begin
            e.push_back(1'b0);
        end else if (t == CMD_END) begin
            while (((m_cnt + e.size()) % ALIGN) != 0) e.push_back(1'b0);
            e_done = 1;
        end
        if (t == CMD_END) begin
            m_cnt   = 0;
            m_first = 1'b1;
        end else begin
            m_cnt = m_cnt + e.size();
            if (m_cnt > (2 ** CNT_W) - 1) m_cnt = (2 ** CNT_W) - 1;
        end
    endfunction

    function automatic int first_diff(input bit a[$], input bit b[$]);
        int n;
        n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    // Issue one command and collect every transferred bit until cmd_ready returns.
    task automatic run_cmd(input hdr_cmd_t t, input logic [7:0] ch, input logic [127:0] p, input int len,
                           input int pct, output bit q[$], output int dn, output int un,
                           output int cyc, output bit tmo);
        bit held;
        bit held_val;
        int w;
        q = {}; dn = 0; un = 0; cyc = 0; tmo = 1'b0;
        held = 1'b0; held_val = 1'b0;
        bus.cmd_type     = t;
        bus.cmd_char     = ch;
        bus.cmd_path     = p;
        bus.cmd_path_len = 8'(len);
        bus.cmd_valid    = 1'b1;
        w = 0;
        while (!bus.cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!bus.cmd_ready) begin
            tmo = 1'b1;
            bus.cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        while (!bus.cmd_ready && cyc < 2000) begin
            if (bus.done) dn++;
            if (bus.bit_valid) begin
                if (held && bus.bit_out !== held_val) un++;
                bus.bit_ready = ($urandom_range(99) < pct);
                if (bus.bit_ready) begin
                    q.push_back(bus.bit_out);
                    held = 1'b0;
                end else begin
                    held     = 1'b1;
                    held_val = bus.bit_out;
                end
            end else begin
                held          = 1'b0;
                bus.bit_ready = 1'($urandom_range(1));
            end
            @(negedge clk);
            cyc++;
        end
        if (!bus.cmd_ready) tmo = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (bus.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_ready got %b want 0", bus.cmd_ready); end
        vectors++; if (bus.bit_valid !== 1'b0) begin miscompares++; $display("FAIL rst_bit_valid got %b want 0", bus.bit_valid); end
        vectors++; if (bus.bit_out !== 1'b0) begin miscompares++; $display("FAIL rst_bit_out got %b want 0", bus.bit_out); end
        vectors++; if (bus.hdr_bits !== 16'd0) begin miscompares++; $display("FAIL rst_hdr_bits got %0d want 0", bus.hdr_bits); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", bus.done); end
        rst = 1'b0;
        m_first = 1'b1;
        m_cnt   = 0;
        @(negedge clk);
        vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_leaf_basic();
        bit q[$], e[$];
        int dn, un, cyc, ed;
        bit tmo;
        logic [11:0] gold;
        gold = 12'b1011_0100_0001;
        model_cmd(CMD_LEAF, 8'h41, 128'b101, 3, e, ed);
        run_cmd(CMD_LEAF, 8'h41, 128'b101, 3, 100, q, dn, un, cyc, tmo);
        vectors++; if (tmo || q.size() != 12) begin miscompares++; $display("FAIL leaf1_len got %0d (tmo %0d) want 12", q.size(), tmo); end
        if (q.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                vectors++; if (q[i] !== gold[11-i]) begin miscompares++; $display("FAIL leaf1_bit%0d got %b want %b", i, q[i], gold[11-i]); end
            end
        end
        vectors++; if (bus.hdr_bits !== 16'd12) begin miscompares++; $display("FAIL leaf1_hdr_bits got %0d want 12", bus.hdr_bits); end
        vectors++; if (cyc != 12) begin miscompares++; $display("FAIL leaf1_cycles got %0d want 12", cyc); end
        vectors++; if (bus.bit_valid !== 1'b0) begin miscompares++; $display("FAIL leaf1_valid_after got %b want 0", bus.bit_valid); end
    endtask

    task automatic test_second_leaf_back();
        bit q[$], e[$];
        int dn, un, cyc, ed;
        bit tmo;
        logic [8:0] gold;
        gold = 9'b1_0100_0010;
        model_cmd(CMD_LEAF, 8'h42, 128'b111, 3, e, ed);
        run_cmd(CMD_LEAF, 8'h42, 128'b111, 3, 100, q, dn, un, cyc, tmo);
        vectors++; if (tmo || q.size() != 9) begin miscompares++; $display("FAIL leaf2_len got %0d want 9", q.size()); end
        if (q.size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                vectors++; if (q[i] !== gold[8-i]) begin miscompares++; $display("FAIL leaf2_bit%0d got %b want %b", i, q[i], gold[8-i]); end
            end
        end
        for (int k = 0; k < 2; k++) begin
            model_cmd(CMD_BACK, 8'h00, 128'h0, 0, e, ed);
            run_cmd(CMD_BACK, 8'h00, 128'h0, 0, 100, q, dn, un, cyc, tmo);
            vectors++; if (tmo || q.size() != 1 || q[0] !== 1'b0) begin miscompares++; $display("FAIL back%0d got %0d bits want one 0", k, q.size()); end
        end
        vectors++; if (bus.hdr_bits !== 16'd23) begin miscompares++; $display("FAIL back_hdr_bits got %0d want 23", bus.hdr_bits); end
    endtask

    task automatic test_end();
        bit q[$], e[$];
        int dn, un, cyc, ed;
        bit tmo;
        logic [7:0] ch;
        model_cmd(CMD_END, 8'h00, 128'h0, 0, e, ed);
        run_cmd(CMD_END, 8'h00, 128'h0, 0, 100, q, dn, un, cyc, tmo);
        vectors++; if (tmo || q.size() != 1 || q[0] !== 1'b0) begin miscompares++; $display("FAIL end23_pad got %0d bits want one 0", q.size()); end
        vectors++; if (dn != 1) begin miscompares++; $display("FAIL end23_done got %0d pulses want 1", dn); end
        vectors++; if (cyc != 2) begin miscompares++; $display("FAIL end23_cycles got %0d want 2", cyc); end
        vectors++; if (bus.hdr_bits !== 16'd0) begin miscompares++; $display("FAIL end23_hdr_bits got %0d want 0", bus.hdr_bits); end

        ch = 8'($urandom());
        model_cmd(CMD_LEAF, ch, 128'h55, 7, e, ed);
        run_cmd(CMD_LEAF, ch, 128'h55, 7, 100, q, dn, un, cyc, tmo);
        vectors++; if (first_diff(q, e) != -1) begin miscompares++; $display("FAIL end_leaf_bits got %0d bits want %0d", q.size(), e.size()); end
        vectors++; if (bus.hdr_bits !== 16'd16) begin miscompares++; $display("FAIL end_leaf_hdr_bits got %0d want 16", bus.hdr_bits); end

        model_cmd(CMD_END, 8'h00, 128'h0, 0, e, ed);
        run_cmd(CMD_END, 8'h00, 128'h0, 0, 100, q, dn, un, cyc, tmo);
        vectors++; if (tmo || q.size() != 0) begin miscompares++; $display("FAIL end16_pad got %0d bits want 0", q.size()); end
        vectors++; if (dn != 1 || cyc != 1) begin miscompares++; $display("FAIL end16_done got %0d pulses in %0d cycles want 1 in 1", dn, cyc); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL end16_done_after got %b want 0", bus.done); end
        vectors++; if (bus.hdr_bits !== 16'd0) begin miscompares++; $display("FAIL end16_hdr_bits got %0d want 0", bus.hdr_bits); end
    endtask

    task automatic test_random();
        bit q[$], e[$];
        int dn, un, cyc, ed, r, len, d;
        bit tmo;
        hdr_cmd_t t;
        logic [7:0] ch;
        logic [127:0] p;
        for (int k = 0; k < 20; k++) begin
            r = int'($urandom_range(9));
            if (r < 5) t = CMD_LEAF;
            else if (r < 8) t = CMD_BACK;
            else if (r == 8) t = CMD_END;
            else t = hdr_cmd_t'(2'd3);
            ch  = 8'($urandom());
            p   = {$urandom(), $urandom(), $urandom(), $urandom()};
            len = ($urandom_range(4) == 0) ? int'($urandom_range(200)) : int'($urandom_range(12));
            model_cmd(t, ch, p, len, e, ed);
            run_cmd(t, ch, p, len, 50, q, dn, un, cyc, tmo);
            vectors++; if (tmo) begin miscompares++; $display("FAIL rand%0d_timeout got no completion want cmd_ready", k); end
            d = first_diff(q, e);
            vectors++; if (d != -1) begin miscompares++; $display("FAIL rand%0d_bits type %0d first diff at %0d got %0d bits want %0d", k, t, d, q.size(), e.size()); end
            vectors++; if (bus.hdr_bits !== 16'(m_cnt)) begin miscompares++; $display("FAIL rand%0d_hdr_bits got %0d want %0d", k, bus.hdr_bits, m_cnt); end
            vectors++; if (dn != ed) begin miscompares++; $display("FAIL rand%0d_done got %0d want %0d", k, dn, ed); end
            vectors++; if (un != 0) begin miscompares++; $display("FAIL rand%0d_stable got %0d changes while stalled want 0", k, un); end
        end
    endtask

    task automatic test_path_clamp();
        bit q[$], e[$];
        int dn, un, cyc, ed, bad;
        bit tmo;
        logic [7:0] ch;
        logic [127:0] p;
        model_cmd(CMD_END, 8'h00, 128'h0, 0, e, ed);
        run_cmd(CMD_END, 8'h00, 128'h0, 0, 100, q, dn, un, cyc, tmo);
        ch = 8'($urandom());
        p  = {$urandom(), $urandom(), $urandom(), $urandom()};
        model_cmd(CMD_LEAF, ch, p, 200, e, ed);
        run_cmd(CMD_LEAF, ch, p, 200, 100, q, dn, un, cyc, tmo);
        vectors++; if (tmo || q.size() != 128 + 1 + CHAR_W) begin miscompares++; $display("FAIL clamp_len got %0d want %0d", q.size(), 128 + 1 + CHAR_W); end
        bad = 0;
        if (q.size() >= 128) begin
            for (int i = 0; i < 128; i++) if (q[i] !== p[127-i]) bad++;
        end
        vectors++; if (bad != 0 || q.size() < 128) begin miscompares++; $display("FAIL clamp_path got %0d wrong bits want 0", bad); end
        vectors++; if (first_diff(q, e) != -1) begin miscompares++; $display("FAIL clamp_stream got diff at %0d want none", first_diff(q, e)); end

        model_cmd(CMD_END, 8'h00, 128'h0, 0, e, ed);
        run_cmd(CMD_END, 8'h00, 128'h0, 0, 100, q, dn, un, cyc, tmo);
        model_cmd(CMD_LEAF, ch, p, 0, e, ed);
        run_cmd(CMD_LEAF, ch, p, 0, 100, q, dn, un, cyc, tmo);
        vectors++; if (tmo || q.size() != 1 + CHAR_W || q[0] !== 1'b1) begin miscompares++; $display("FAIL len0_mark got %0d bits want %0d starting with 1", q.size(), 1 + CHAR_W); end
        vectors++; if (first_diff(q, e) != -1) begin miscompares++; $display("FAIL len0_stream got diff at %0d want none", first_diff(q, e)); end
    endtask

    task automatic test_rst_mid();
        bit q[$], e[$];
        int dn, un, cyc, ed;
        bit tmo;
        bus.cmd_type     = CMD_LEAF;
        bus.cmd_char     = 8'h5A;
        bus.cmd_path     = 128'b110;
        bus.cmd_path_len = 8'd3;
        bus.bit_ready    = 1'b1;
        bus.cmd_valid    = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (bus.bit_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_valid got %b want 1", bus.bit_valid); end
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (bus.bit_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid got %b want 0", bus.bit_valid); end
        vectors++; if (bus.hdr_bits !== 16'd0) begin miscompares++; $display("FAIL rstmid_hdr_bits got %0d want 0", bus.hdr_bits); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL rstmid_done got %b want 0", bus.done); end
        vectors++; if (bus.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready got %b want 0", bus.cmd_ready); end
        rst     = 1'b0;
        m_first = 1'b1;
        m_cnt   = 0;
        @(negedge clk);
        vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready_after got %b want 1", bus.cmd_ready); end
        model_cmd(CMD_LEAF, 8'h33, 128'b011, 3, e, ed);
        run_cmd(CMD_LEAF, 8'h33, 128'b011, 3, 100, q, dn, un, cyc, tmo);
        vectors++; if (tmo || q.size() != 12) begin miscompares++; $display("FAIL rstmid_leaf_len got %0d want 12", q.size()); end
        vectors++; if (first_diff(q, e) != -1) begin miscompares++; $display("FAIL rstmid_leaf_bits got diff at %0d want none", first_diff(q, e)); end
        vectors++; if (bus.hdr_bits !== 16'd12) begin miscompares++; $display("FAIL rstmid_hdr_after got %0d want 12", bus.hdr_bits); end
    endtask

    initial begin
        bus.cmd_valid    = 1'b0;
        bus.cmd_type     = CMD_LEAF;
        bus.cmd_char     = '0;
        bus.cmd_path     = '0;
        bus.cmd_path_len = '0;
        bus.bit_ready    = 1'b0;
        test_reset();
        test_leaf_basic();
        test_second_leaf_back();
        test_end();
        test_random();
        test_path_clamp();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
